// File: rtl/write_back_unit.sv
`default_nettype none
// ============================================================================
// Module   : write_back_unit
// Purpose  : Final pipeline stage. Accepts decoded write-back requests and
//            produces a registered register-file write. ALU / PC+4 results
//            are written the cycle after acceptance. Loads park the unit in
//            WAIT_MEM until the memory response arrives; the raw word is then
//            byte/half selected and sign/zero extended. Bus errors,
//            misaligned accesses, illegal load widths and response timeouts
//            raise a one-cycle load_fault instead of a write.
// Ports    : clk, reset_n (async, active-low)
//            in_valid/in_ready       - request handshake
//            write_enable, addr_rd   - destination register controls
//            wb_sel                  - 00 ALU, 01 MEM, 10 PC (11 treated as ALU)
//            alu_result, pc_plus4    - non-load write-back sources
//            load_funct3, load_addr_lo - load width/sign and byte offset
//            mem_rvalid, mem_rdata, mem_err - load response
//            rf_we, rf_waddr, rf_wdata - registered register-file write port
//            load_fault              - one-cycle pulse on a faulted load
//            instret                 - 64-bit retired-instruction counter
// Revision : 1.0 - initial release
// ============================================================================
module write_back_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        write_enable,
    input  logic [4:0]  addr_rd,
    input  logic [1:0]  wb_sel,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        load_fault,
    output logic [63:0] instret
);

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;

    // Counter value seen in the last permitted no-response cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    // Request fields captured at acceptance; only loads consume them later.
    // wb_sel itself need not be stored: being in WAIT_MEM already means MEM.
    logic        we_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        load_fault_q, load_fault_d;
    logic [63:0] instret_q, instret_d;

    logic        accept;
    logic        retire;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        ld_fault;

    // ------------------------------------------------------------------
    // Load data extraction and fault classification (uses captured fields)
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        ld_data  = 32'h0000_0000;
        ld_fault = mem_err;

        unique case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        unique case (funct3_q)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'h000000, ld_byte};
            3'b001: begin
                ld_data = {{16{ld_half[15]}}, ld_half};
                if (addr_lo_q[0]) ld_fault = 1'b1;
            end
            3'b101: begin
                ld_data = {16'h0000, ld_half};
                if (addr_lo_q[0]) ld_fault = 1'b1;
            end
            3'b010: begin
                ld_data = mem_rdata;
                if (addr_lo_q != 2'd0) ld_fault = 1'b1;
            end
            default: ld_fault = 1'b1;   // 011, 110, 111 are not legal loads
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;     // hold last written address/data
        rf_wdata_d   = rf_wdata_q;
        load_fault_d = 1'b0;
        retire       = 1'b0;
        accept       = 1'b0;
        in_ready     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (wb_sel == WB_SEL_MEM) begin
                        state_d    = S_WAIT_MEM;
                        wait_cnt_d = 8'd0;
                    end else begin
                        retire = 1'b1;
                        if (write_enable && (addr_rd != 5'd0)) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = addr_rd;
                            unique case (wb_sel)
                                WB_SEL_ALU: rf_wdata_d = alu_result;
                                WB_SEL_PC:  rf_wdata_d = pc_plus4;
                                default:    rf_wdata_d = alu_result;
                            endcase
                        end
                    end
                end
            end

            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d = S_IDLE;
                    if (ld_fault) begin
                        load_fault_d = 1'b1;
                    end else begin
                        retire = 1'b1;
                        if (we_q && (rd_q != 5'd0)) begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = rd_q;
                            rf_wdata_d = ld_data;
                        end
                    end
                end else if (wait_cnt_q >= TIMEOUT_LAST) begin
                    state_d      = S_IDLE;
                    load_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        instret_d = instret_q + {63'd0, retire};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            we_q         <= 1'b0;
            rd_q         <= 5'd0;
            funct3_q     <= 3'd0;
            addr_lo_q    <= 2'd0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= 5'd0;
            rf_wdata_q   <= 32'h0000_0000;
            load_fault_q <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            load_fault_q <= load_fault_d;
            instret_q    <= instret_d;
            if (accept) begin
                we_q      <= write_enable;
                rd_q      <= addr_rd;
                funct3_q  <= load_funct3;
                addr_lo_q <= load_addr_lo;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign load_fault = load_fault_q;
    assign instret    = instret_q;

endmodule
`default_nettype wire

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max cycles in WAIT_MEM before timeout fault (range 1..255).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; one clock only.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 in_valid  in  1  decoded write-back request present.
REQ-005 in_ready  out  1  unit can accept a request this cycle.
REQ-006 write_enable  in  1  reg_file_write_params.write_enable from decode.
REQ-007 addr_rd  in  5  reg_file_write_params.addr_rd from decode.
REQ-008 wb_sel  in  write_back_select_t  WRITE_BACK_SEL_ALU / _MEM / _PC.
REQ-009 alu_result  in  32  ALU result.
REQ-010 pc_plus4  in  32  PC+4 of the instruction.
REQ-011 load_funct3  in  3  load width/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-012 load_addr_lo  in  2  load address bits [1:0].
REQ-013 mem_rvalid  in  1  load data response valid.
REQ-014 mem_rdata  in  32  raw aligned-word load data.
REQ-015 mem_err  in  1  bus error, qualified by mem_rvalid.
REQ-016 rf_we / rf_waddr / rf_wdata  out  1/5/32  register-file write port, registered.
REQ-017 load_fault  out  1  one-cycle pulse on a faulted load.
REQ-018 instret  out  64  retired-instruction counter.

Function
REQ-019 SHALL implement states IDLE and WAIT_MEM; in_ready SHALL be 1 in IDLE and 0 in WAIT_MEM.
REQ-020 Acceptance in cycle N = in_valid & in_ready; unit SHALL capture addr_rd, write_enable, wb_sel, load_funct3, load_addr_lo on acceptance.
REQ-021 Non-load accepted in N SHALL drive rf_we=(write_enable & addr_rd!=0) for exactly cycle N+1, with rf_wdata = alu_result (ALU) or pc_plus4 (PC); state stays IDLE; back-to-back acceptance every cycle SHALL be supported.
REQ-022 Load (wb_sel=MEM) accepted in N SHALL move to WAIT_MEM in N+1; mem_rvalid in IDLE SHALL be ignored.
REQ-023 In WAIT_MEM, mem_rvalid=1 & mem_err=0 in cycle M SHALL produce rf_we pulse in M+1 with extended data and return to IDLE in M+1.
REQ-024 Extension: LB/LBU use byte mem_rdata[8*addr_lo+7:8*addr_lo], LH/LHU use half mem_rdata[16*addr_lo[1]+15:16*addr_lo[1]]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word unchanged.
REQ-025 Fault on response (no rf_we, load_fault pulse in M+1, return to IDLE): mem_err=1; LH/LHU with addr_lo[0]=1; LW with addr_lo!=0; funct3 in {011,110,111}.
REQ-026 A 8-bit wait counter SHALL clear on entering WAIT_MEM and increment each WAIT_MEM cycle without mem_rvalid; reaching TIMEOUT_CYCLES SHALL pulse load_fault next cycle, no write, return to IDLE.
REQ-027 rf_we SHALL never assert for rf_waddr=0; rf_waddr/rf_wdata hold last value when rf_we=0.
REQ-028 instret SHALL increment by 1 in the cycle rf_we would pulse for every completed request (including write_enable=0 and rd=0), not for faulted loads; SHALL wrap from 2^64-1 to 0.
REQ-029 load_fault and rf_we SHALL never assert in the same cycle.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, load_fault=0, instret=0, wait counter=0; in_ready=1 after reset.
REQ-031 Reset asserted in WAIT_MEM SHALL abandon the load without write; a mem_rvalid after reset release SHALL be ignored.

Verification
REQ-032 ALU op rd=5, alu_result=0x1234_5678, accepted cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678 in N+1 only; instret=1.
REQ-033 JAL rd=1, pc_plus4=0x0000_0104, followed next cycle by store (write_enable=0) -> rf_we pulse for x1 in N+1, no write in N+2, instret=2.
REQ-034 LB addr_lo=3, mem_rdata=0x80AA_BBCC, rvalid 4 cycles after acceptance -> in_ready=0 during wait, rf_wdata=0xFFFF_FF80; LHU addr_lo=2, same data -> 0x0000_80AA.
REQ-035 LW addr_lo=1 response, and separately mem_err=1 response -> load_fault one-cycle pulse, rf_we=0, instret unchanged.
REQ-036 TIMEOUT_CYCLES=4, load with no rvalid -> load_fault after 4 wait cycles, back to IDLE, in_ready=1.
REQ-037 ALU op rd=0, and reset_n pulsed low during WAIT_MEM -> no rf_we for x0 (instret increments); after reset all outputs zero, late rvalid produces no write.
